// File: rtl/l1_pkg.sv
// Shared definitions for the L1 instruction-cache command path:
// command encodings, issuer FSM states and default address width.
package l1_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 60;

  typedef enum logic [2:0] {
    READ          = 3'd0,
    WRITE         = 3'd1,
    INVALIDATE    = 3'd2,
    CLEAR         = 3'd3,
    L2DATAREQUEST = 3'd4
  } cmd_e;

  localparam logic [2:0] CMD_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_DONE
  } state_e;

  function automatic logic cmd_legal(input logic [2:0] code);
    return code <= CMD_MAX;
  endfunction

endpackage

// File: rtl/l1_cmd_fifo.sv
// Synchronous FIFO of {cmd, addr} entries; full/empty derived from an
// extra pointer MSB so all DEPTH slots are usable.
module l1_cmd_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = l1_pkg::ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W+2:0] wdata,
  output logic [ADDR_W+2:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [ADDR_W+2:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/l1_cmd_issuer.sv
// Feeds buffered trace commands to the L1 I-cache one at a time over its
// write/processing handshake, dropping illegal codes and guarding with a watchdog.
module l1_cmd_issuer
  import l1_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_cmd,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              cache_processing,
  output logic              cache_write,
  output logic [2:0]        cache_command,
  output logic [ADDR_W-1:0] cache_address,
  output logic              idle,
  output logic              timeout_err,
  output logic [63:0]       issued_cnt,
  output logic [63:0]       dropped_cnt,
  output logic [63:0]       timeout_cnt
);

  state_e            state;
  logic [31:0]       wdog;
  logic              full;
  logic              empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic [ADDR_W+2:0] head;

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && cmd_legal(in_cmd);
  assign pop      = (state == ST_IDLE) && !empty;
  assign idle     = empty && (state == ST_IDLE);

  l1_cmd_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({in_cmd, in_addr}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      wdog          <= '0;
      cache_write   <= 1'b0;
      cache_command <= '0;
      cache_address <= '0;
      timeout_err   <= 1'b0;
      issued_cnt    <= '0;
      dropped_cnt   <= '0;
      timeout_cnt   <= '0;
    end else begin
      if (accept && !cmd_legal(in_cmd)) dropped_cnt <= dropped_cnt + 64'd1;

      if (state == ST_IDLE) begin
        if (!empty) begin
          cache_command <= head[ADDR_W+2:ADDR_W];
          cache_address <= head[ADDR_W-1:0];
          cache_write   <= 1'b1;
          wdog          <= '0;
          state         <= ST_ISSUE;
        end
      end else if (wdog == 32'(TIMEOUT - 1)) begin
        // Watchdog outranks the handshake: the command is abandoned, never retried.
        timeout_err <= 1'b1;
        timeout_cnt <= timeout_cnt + 64'd1;
        cache_write <= 1'b0;
        state       <= ST_IDLE;
      end else begin
        wdog <= wdog + 32'd1;
        case (state)
          ST_ISSUE: begin
            if (!cache_processing) begin
              cache_write <= 1'b0;
              issued_cnt  <= issued_cnt + 64'd1;
              state       <= ST_WAIT_START;
            end
          end
          ST_WAIT_START: if (cache_processing) state <= ST_WAIT_DONE;
          ST_WAIT_DONE:  if (!cache_processing) state <= ST_IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_l1_cmd_issuer.sv
// Randomised and directed bench for l1_cmd_issuer against a transaction-level
// model of the FIFO plus the per-command issue/handshake/watchdog lifecycle.
module tb_l1_cmd_issuer;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned ADDR_W  = 60;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_cmd = '0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic              cache_processing = 1'b0;
  logic              cache_write;
  logic [2:0]        cache_command;
  logic [ADDR_W-1:0] cache_address;
  logic              idle;
  logic              timeout_err;
  logic [63:0]       issued_cnt;
  logic [63:0]       dropped_cnt;
  logic [63:0]       timeout_cnt;

  int checks = 0;
  int failures = 0;
  int wr_cycles = 0;

  l1_cmd_issuer #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_cmd           (in_cmd),
    .in_addr          (in_addr),
    .cache_processing (cache_processing),
    .cache_write      (cache_write),
    .cache_command    (cache_command),
    .cache_address    (cache_address),
    .idle             (idle),
    .timeout_err      (timeout_err),
    .issued_cnt       (issued_cnt),
    .dropped_cnt      (dropped_cnt),
    .timeout_cnt      (timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of pending entries and one in-flight command
  // that moves through "issued" and "cache started" milestones.
  logic [ADDR_W+2:0] m_q[$];
  bit                m_busy, m_issued, m_started, m_err;
  int unsigned       m_age;
  logic [2:0]        m_cmd;
  logic [ADDR_W-1:0] m_addr;
  logic [63:0]       m_iss, m_drop, m_tmo;

  task automatic model_step();
    int unsigned sz;
    bit          do_push;
    logic [ADDR_W+2:0] e;
    if (!rst) begin
      m_q.delete();
      m_busy = 0; m_issued = 0; m_started = 0; m_err = 0; m_age = 0;
      m_cmd = '0; m_addr = '0; m_iss = '0; m_drop = '0; m_tmo = '0;
      return;
    end
    sz = m_q.size();
    do_push = in_valid && (sz < DEPTH);
    if (m_busy) begin
      m_age++;
      if (m_age >= TIMEOUT) begin
        m_busy = 0; m_err = 1; m_tmo++;
      end else if (!m_issued) begin
        if (!cache_processing) begin m_issued = 1; m_iss++; end
      end else if (!m_started) begin
        if (cache_processing) m_started = 1;
      end else if (!cache_processing) begin
        m_busy = 0;
      end
    end else if (sz > 0) begin
      e = m_q.pop_front();
      m_cmd = e[ADDR_W+2:ADDR_W]; m_addr = e[ADDR_W-1:0];
      m_busy = 1; m_issued = 0; m_started = 0; m_age = 0;
    end
    if (do_push) begin
      if (in_cmd <= 3'd4) m_q.push_back({in_cmd, in_addr});
      else m_drop++;
    end
  endtask

  initial begin
    model_step();
    forever begin
      @(posedge clk or negedge rst);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cache_write) wr_cycles++;
      chk("in_ready", 64'(in_ready), 64'(m_q.size() < DEPTH));
      chk("idle", 64'(idle), 64'(m_q.size() == 0 && !m_busy));
      chk("cache_write", 64'(cache_write), 64'(m_busy && !m_issued));
      chk("cache_command", 64'(cache_command), 64'(m_cmd));
      chk("cache_address", 64'(cache_address), 64'(m_addr));
      chk("timeout_err", 64'(timeout_err), 64'(m_err));
      chk("issued_cnt", issued_cnt, m_iss);
      chk("dropped_cnt", dropped_cnt, m_drop);
      chk("timeout_cnt", timeout_cnt, m_tmo);
    end
  end

  // Cache responder: 0 = latch then busy for hold_len cycles, 1 = always busy,
  // 2 = latch then busy forever, 3 = random busy.
  int cmode = 0;
  int hold_len = 2;
  int hold_cnt = 0;
  initial begin
    bit latch;
    forever begin
      @(negedge clk);
      latch = cache_write && !cache_processing && rst;
      @(posedge clk);
      #1;
      case (cmode)
        1: cache_processing = 1'b1;
        2: if (latch) cache_processing = 1'b1;
        3: cache_processing = ($urandom_range(0, 3) == 0);
        default: begin
          if (latch) hold_cnt = hold_len;
          if (hold_cnt > 0) begin
            cache_processing = 1'b1;
            hold_cnt--;
          end else begin
            cache_processing = 1'b0;
          end
        end
      endcase
    end
  end

  task automatic push(input logic [2:0] c, input logic [ADDR_W-1:0] a, input string name);
    bit ok;
    bit r;
    ok = 0;
    in_valid = 1'b1; in_cmd = c; in_addr = a;
    for (int i = 0; i < 100; i++) begin
      r = in_ready;
      @(posedge clk); #2;
      if (r) begin ok = 1; break; end
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s push_accepted actual=0 required=1", name);
    end
  endtask

  task automatic wait_idle(input int unsigned lim, input string name);
    bit ok;
    ok = 0;
    for (int unsigned i = 0; i < lim; i++) begin
      @(posedge clk); #2;
      if (idle && !cache_write) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s reached_idle actual=0 required=1", name);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({name, "_idle"}, 64'(idle), 64'd1);
    chk({name, "_cache_write"}, 64'(cache_write), 64'd0);
    chk({name, "_cache_command"}, 64'(cache_command), 64'd0);
    chk({name, "_cache_address"}, 64'(cache_address), 64'd0);
    chk({name, "_timeout_err"}, 64'(timeout_err), 64'd0);
    chk({name, "_issued"}, issued_cnt, 64'd0);
    chk({name, "_dropped"}, dropped_cnt, 64'd0);
    chk({name, "_timeouts"}, timeout_cnt, 64'd0);
  endtask

  initial begin
    int  w0;
    int  accepted;
    bit  r;
    bit  seen;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;

    // Single READ, cache busy for two cycles after the latch edge.
    cmode = 0; hold_len = 2;
    w0 = wr_cycles;
    push(3'd0, 60'h40, "single_read");
    wait_idle(50, "single_read");
    chk("single_write_cycles", 64'(wr_cycles - w0), 64'd1);
    chk("single_addr", 64'(cache_address), 64'h40);
    chk("single_cmd", 64'(cache_command), 64'd0);
    chk("single_issued", issued_cnt, 64'd1);
    chk("single_idle", 64'(idle), 64'd1);

    // Fill with the cache stuck busy: one entry parks in ISSUE, DEPTH more fill the FIFO.
    cmode = 1;
    repeat (2) @(posedge clk);
    #2;
    accepted = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_cmd = 3'(i % 5);
      in_addr = 60'h100 + 60'(i);
      r = in_ready;
      if (!r) break;
      @(posedge clk); #2;
      accepted++;
    end
    chk("fill_accepted", 64'(accepted), 64'(DEPTH + 1));
    chk("fill_ready_low", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    chk("fill_held_off", 64'(in_ready), 64'd0);
    cmode = 0; hold_len = 1;
    push(3'(9 % 5), 60'h109, "fill_last");
    wait_idle(200, "fill_drain");
    chk("fill_issued", issued_cnt, 64'd11);
    chk("fill_last_addr", 64'(cache_address), 64'h109);
    chk("fill_timeouts", timeout_cnt, 64'd0);

    // Illegal code dropped, legal CLEAR issued.
    hold_len = 2;
    push(3'd6, 60'h200, "drop_bad");
    push(3'd3, 60'h300, "drop_good");
    wait_idle(50, "drop");
    chk("drop_dropped", dropped_cnt, 64'd1);
    chk("drop_issued", issued_cnt, 64'd12);
    chk("drop_cmd", 64'(cache_command), 64'd3);
    chk("drop_addr", 64'(cache_address), 64'h300);

    // Cache accepts but never finishes: watchdog abandons the command.
    cmode = 2;
    push(3'd1, 60'h500, "tmo_push");
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (timeout_err) begin seen = 1; break; end
    end
    chk("tmo_seen", 64'(seen), 64'd1);
    chk("tmo_cnt", timeout_cnt, 64'd1);
    chk("tmo_issued", issued_cnt, 64'd13);
    chk("tmo_idle", 64'(idle), 64'd1);
    chk("tmo_write", 64'(cache_write), 64'd0);
    // Next command meets a still-busy cache and parks in ISSUE.
    push(3'd2, 60'h600, "park_push");
    repeat (4) @(posedge clk);
    #2;
    chk("park_write", 64'(cache_write), 64'd1);
    chk("park_issued", issued_cnt, 64'd13);
    cmode = 0; hold_len = 2;
    wait_idle(50, "park");
    chk("park_issued_after", issued_cnt, 64'd14);
    chk("park_timeouts", timeout_cnt, 64'd1);
    chk("park_cmd", 64'(cache_command), 64'd2);
    chk("park_err_sticky", 64'(timeout_err), 64'd1);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cmode = (i < 200) ? 3 : 0;
      hold_len = int'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      in_cmd = 3'($urandom_range(0, 7));
      in_addr = 60'({$urandom(), $urandom()});
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    cmode = 0; hold_len = 1;
    wait_idle(400, "random_drain");

    // Reset in the middle of WAIT_DONE with three entries still queued.
    hold_len = 6;
    push(3'd0, 60'h700, "rst_p0");
    push(3'd1, 60'h701, "rst_p1");
    push(3'd2, 60'h702, "rst_p2");
    push(3'd4, 60'h703, "rst_p3");
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    chk("midrst_no_issue", issued_cnt, 64'd0);
    chk("midrst_idle", 64'(idle), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

endmodule
